// File: rtl/neureka_package.sv
// Shared NEUREKA definitions: mode encodings, accumulator width and the
// control/state types used by the accumulator unpacker.
package neureka_package;

  localparam int NEUREKA_ACCUM_SIZE   = 32;
  localparam int NEUREKA_UNPACK_LEN_W = 16;

  localparam logic [1:0] NEUREKA_MODE_8B  = 2'b00;
  localparam logic [1:0] NEUREKA_MODE_16B = 2'b01;
  localparam logic [1:0] NEUREKA_MODE_32B = 2'b10;

  typedef struct packed {
    logic [1:0]                      mode;
    logic                            is_signed;
    logic [4:0]                      shift;
    logic [NEUREKA_UNPACK_LEN_W-1:0] len;
    logic                            start;
  } ctrl_unpack_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } unpack_state_e;

  // Index of the last lane in a word; the illegal encoding behaves as 32B.
  function automatic logic [1:0] last_lane(input logic [1:0] mode);
    case (mode)
      NEUREKA_MODE_8B:  last_lane = 2'd3;
      NEUREKA_MODE_16B: last_lane = 2'd1;
      default:          last_lane = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/neureka_accum_unpacker_lane.sv
// Combinational lane select, widen to 33 bits and optional shift/saturate.
// Shifter present only when NEUREKA_ACCUM_UNPACKER_SHIFT_EN is defined.
module neureka_accum_unpacker_lane
  import neureka_package::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  mode_i,
  input  logic [1:0]  lane_i,
  input  logic        signed_i,
  input  logic [4:0]  shift_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [32:0] ext;

  assign lane8  = word_i[{lane_i, 3'b000} +: 8];
  assign lane16 = word_i[{lane_i[0], 4'b0000} +: 16];

  always_comb begin
    case (mode_i)
      NEUREKA_MODE_8B:  ext = {{25{signed_i & lane8[7]}}, lane8};
      NEUREKA_MODE_16B: ext = {{17{signed_i & lane16[15]}}, lane16};
      default:          ext = {signed_i & word_i[31], word_i};
    endcase
  end

`ifdef NEUREKA_ACCUM_UNPACKER_SHIFT_EN
  logic [63:0] wide;
  logic        sat_pos;
  logic        sat_neg;

  // 33-bit value shifted by at most 31 always fits in 64 signed bits.
  assign wide    = {{31{ext[32]}}, ext} << shift_i;
  assign sat_pos = !wide[63] && (|wide[62:31]);
  assign sat_neg = wide[63] && !(&wide[62:31]);

  always_comb begin
    if (sat_pos)      data_o = 32'h7FFF_FFFF;
    else if (sat_neg) data_o = 32'h8000_0000;
    else              data_o = wide[31:0];
  end
`else
  logic unused_shift;
  assign unused_shift = ^shift_i;

  // Only unsigned 32-bit lanes can exceed the signed accumulator range.
  assign data_o = (!ext[32] && ext[31]) ? 32'h7FFF_FFFF : ext[31:0];
`endif

endmodule

// File: rtl/neureka_accum_unpacker.sv
// Unpacks 8/16/32-bit lanes from streamer words into signed accumulator values.
// Optional shift/saturate path: NEUREKA_ACCUM_UNPACKER_SHIFT_EN.
module neureka_accum_unpacker
  import neureka_package::*;
#(
  parameter int ACC   = NEUREKA_ACCUM_SIZE,
  parameter int BW    = 32,
  parameter int LEN_W = NEUREKA_UNPACK_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic             signed_i,
  input  logic [4:0]       shift_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [BW-1:0]    in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [ACC-1:0]   out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  unpack_state_e    state_q, state_d;
  logic [BW-1:0]    word_q, word_d;
  logic [1:0]       lane_q, lane_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [1:0]       mode_q, mode_d;
  logic             signed_q, signed_d;
  logic [4:0]       shift_q, shift_d;
  logic             done_q, done_d;

  ctrl_unpack_t     ctrl;
  logic             final_hs;
  logic [ACC-1:0]   lane_data;

  assign ctrl.mode      = mode_i;
  assign ctrl.is_signed = signed_i;
  assign ctrl.shift     = shift_i;
  assign ctrl.len       = NEUREKA_UNPACK_LEN_W'(len_i);
  assign ctrl.start     = start_i;

  assign final_hs = (state_q == EMIT) && out_ready_i &&
                    (remaining_q == LEN_W'(1)) && !clear_i;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    lane_d      = lane_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    signed_d    = signed_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl.start) begin
            mode_d      = ctrl.mode;
            signed_d    = ctrl.is_signed;
            shift_d     = ctrl.shift;
            remaining_d = LEN_W'(ctrl.len);
            if (ctrl.len == '0) done_d = 1'b1;
            else                state_d = FETCH;
          end
        end
        FETCH: begin
          if (in_valid_i) begin
            word_d  = in_data_i;
            lane_d  = 2'd0;
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (out_ready_i) begin
            remaining_d = remaining_q - LEN_W'(1);
            lane_d      = lane_q + 2'd1;
            if (remaining_q == LEN_W'(1))         state_d = IDLE;
            else if (lane_q == last_lane(mode_q)) state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      word_q      <= '0;
      lane_q      <= '0;
      remaining_q <= '0;
      mode_q      <= '0;
      signed_q    <= 1'b0;
      shift_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      signed_q    <= signed_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
    end
  end

  neureka_accum_unpacker_lane u_lane (
    .word_i   (word_q),
    .mode_i   (mode_q),
    .lane_i   (lane_q),
    .signed_i (signed_q),
    .shift_i  (shift_q),
    .data_o   (lane_data)
  );

  assign in_ready_o  = (state_q == FETCH);
  assign out_valid_o = (state_q == EMIT);
  assign busy_o      = (state_q != IDLE);
  // Data is forced to zero outside EMIT so idle outputs read as 0.
  assign out_data_o  = out_valid_o ? lane_data : '0;
  assign done_o      = done_q | final_hs;

endmodule

// File: tb/tb_neureka_accum_unpacker.sv
// Randomized and directed checks of neureka_accum_unpacker against an
// arithmetic reference model.
module tb_neureka_accum_unpacker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic        start_i;
  logic [1:0]  mode_i;
  logic        signed_i;
  logic [4:0]  shift_i;
  logic [15:0] len_i;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] words[$];

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  always #5 clk_i = ~clk_i;

  neureka_accum_unpacker dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .signed_i    (signed_i),
    .shift_i     (shift_i),
    .len_i       (len_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_bits(input logic [1:0] m);
    return (m == 2'd0) ? 8 : (m == 2'd1) ? 16 : 32;
  endfunction

  // Element k of the stream, computed from the word list by plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] m, input bit s, input int sh, input int k);
    int     bits = lane_bits(m);
    int     per  = 32 / bits;
    longint w    = longint'({32'd0, words[k / per]});
    longint raw  = (w >> (bits * (k % per))) & ((64'sd1 <<< bits) - 1);
    longint v    = raw;
    if (s && raw[bits-1]) v = raw - (64'sd1 <<< bits);
`ifdef NEUREKA_ACCUM_UNPACKER_SHIFT_EN
    v = v * (64'sd1 <<< sh);
`else
    if (sh < 0) v = 0;
`endif
    if (v > MAXV) return 32'h7FFF_FFFF;
    if (v < MINV) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic do_start(input logic [1:0] m, input bit s, input int sh, input int len);
    @(negedge clk_i);
    start_i  = 1'b1;
    mode_i   = m;
    signed_i = s;
    shift_i  = 5'(sh);
    len_i    = 16'(len);
    @(negedge clk_i);
    start_i  = 1'b0;
    mode_i   = 2'(($urandom));
    shift_i  = 5'($urandom);
  endtask

  task automatic run_job(input string name, input logic [1:0] m, input bit s, input int sh,
                         input int len, input bit stall);
    int per    = 32 / lane_bits(m);
    int nwords = (len + per - 1) / per;
    int got    = 0;
    int widx   = 0;
    int cyc    = 0;
    bit hs;
    do_start(m, s, sh, len);
    while (got < len && cyc < 2000) begin
      cyc++;
      out_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid_i  = ($urandom_range(0, 3) != 0) && (widx < words.size());
      in_data_i   = in_valid_i ? words[widx] : $urandom;
      #1;
      hs = out_valid_o && out_ready_i;
      if (in_valid_i && in_ready_o) widx++;
      if (out_valid_o) check_eq({name, "_data"}, out_data_o, model(m, s, sh, got));
      check_eq({name, "_done"}, 32'(done_o), 32'(hs && got == len - 1));
      if (hs) got++;
      @(negedge clk_i);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    if (cyc >= 2000) check_eq({name, "_timeout"}, 32'd0, 32'd1);
    #1;
    check_eq({name, "_idle_busy"}, 32'(busy_o), 32'd0);
    check_eq({name, "_idle_done"}, 32'(done_o), 32'd0);
    check_eq({name, "_in_hs"}, 32'(widx), 32'(nwords));
    $display("job %s mode=%0d signed=%0d shift=%0d len=%0d stall=%0d elems=%0d words=%0d",
             name, m, s, sh, len, stall, got, widx);
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; mode_i = 2'd0; signed_i = 1'b0;
    shift_i = 5'd0; len_i = 16'd0; in_data_i = 32'd0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    #12;
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst_ready", 32'(in_ready_o), 32'd0);
    check_eq("rst_data", out_data_o, 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    words = '{32'h80FF_7F01};
    run_job("s8", 2'd0, 1'b1, 0, 4, 1'b0);
    words = '{32'hFFFF_1234, 32'h0000_ABCD};
    run_job("u16", 2'd1, 1'b0, 0, 3, 1'b0);
    words = '{32'h8000_0000};
    run_job("u32sat", 2'd2, 1'b0, 0, 1, 1'b0);
    words = '{32'h8000_0000, 32'hFFFF_FFFF};
    run_job("mode3", 2'd3, 1'b1, 0, 2, 1'b1);
`ifdef NEUREKA_ACCUM_UNPACKER_SHIFT_EN
    words = '{32'hF7F8_0807};
    run_job("sh28", 2'd0, 1'b1, 28, 4, 1'b0);
`endif

    // Same data with and without downstream stalls.
    words = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
    run_job("nostall", 2'd0, 1'b1, 3, 11, 1'b0);
    run_job("stall", 2'd0, 1'b1, 3, 11, 1'b1);

    for (int j = 0; j < 30; j++) begin
      logic [1:0] m  = 2'($urandom);
      int         ln = $urandom_range(1, 12);
      words.delete();
      for (int i = 0; i < 12; i++)
        words.push_back((i % 3 == 0) ? {$urandom_range(0, 1) ? 8'h80 : 8'h7F, 24'($urandom)} : $urandom);
      run_job("rnd", m, 1'($urandom), $urandom_range(0, 31), ln, 1'($urandom));
    end

    // Zero-length job: done one cycle after start, no fetch.
    @(negedge clk_i);
    start_i = 1'b1; len_i = 16'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("len0_done", 32'(done_o), 32'd1);
    check_eq("len0_ready", 32'(in_ready_o), 32'd0);
    check_eq("len0_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check_eq("len0_done_end", 32'(done_o), 32'd0);
    $display("job len0 done checked");

    // Clear in the middle of EMIT.
    words = '{32'h1122_3344};
    do_start(2'd0, 1'b0, 0, 8);
    in_valid_i = 1'b1; in_data_i = words[0];
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check_eq("clr_pre_valid", 32'(out_valid_o), 32'd1);
    clear_i = 1'b1; out_ready_i = 1'b0;
    @(negedge clk_i);
    clear_i = 1'b0;
    check_eq("clr_valid", 32'(out_valid_o), 32'd0);
    check_eq("clr_busy", 32'(busy_o), 32'd0);
    check_eq("clr_done", 32'(done_o), 32'd0);
    $display("job clear mid-EMIT checked");

    // Start together with clear is dropped.
    @(negedge clk_i);
    start_i = 1'b1; clear_i = 1'b1; len_i = 16'd0;
    @(negedge clk_i);
    start_i = 1'b0; clear_i = 1'b0;
    check_eq("clrstart_done", 32'(done_o), 32'd0);
    check_eq("clrstart_busy", 32'(busy_o), 32'd0);
    $display("job start+clear checked");

    // Reset asserted while waiting in FETCH.
    do_start(2'd1, 1'b1, 0, 5);
    check_eq("rstmid_pre_ready", 32'(in_ready_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("rstmid_ready", 32'(in_ready_o), 32'd0);
    check_eq("rstmid_busy", 32'(busy_o), 32'd0);
    check_eq("rstmid_valid", 32'(out_valid_o), 32'd0);
    check_eq("rstmid_data", out_data_o, 32'd0);
    check_eq("rstmid_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    $display("job reset mid-FETCH checked");

    words = '{32'hCAFE_F00D};
    run_job("post_rst", 2'd1, 1'b1, 1, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
